// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage control slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIR
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter used for the fetch performance statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Holds at all-ones instead of wrapping so long stalls never read as small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC register, the IMEM request and the
// IF/ID and ID/EX hold/flush controls from IMEM wait, load-use and branches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             load_use_stall,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  output logic             imem_req,
  output logic             pc_src,
  output logic             pc_en_n,
  output logic [XLEN-1:0]  pcj,
  output logic             ifid_en_n,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            stall_inc, flush_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // Defaults are the safe "hold everything, flush both stages" values, which
  // are also what the pipeline sees while rst_n is low.
  always_comb begin
    imem_req   = 1'b0;
    pc_src     = 1'b0;
    pc_en_n    = 1'b1;
    pcj        = '0;
    ifid_en_n  = 1'b1;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    state_d    = state_q;
    tgt_d      = tgt_q;
    if (rst_n) begin
      case (state_q)
        S_BOOT: begin
          pc_src  = 1'b1;
          pcj     = RESET_VEC;
          pc_en_n = 1'b0;
          state_d = S_RUN;
        end
        S_RUN: begin
          imem_req = 1'b1;
          pcj      = br_target;
          if (br_taken) begin
            if (imem_ready) begin
              pc_src    = 1'b1;
              pc_en_n   = 1'b0;
              flush_inc = 1'b1;
            end else begin
              // Request still outstanding: park the target until IMEM answers.
              tgt_d   = br_target;
              state_d = S_REDIR;
            end
          end else if (load_use_stall) begin
            ifid_flush = 1'b0;
            stall_inc  = 1'b1;
          end else if (!imem_ready) begin
            idex_flush = 1'b0;
            stall_inc  = 1'b1;
          end else begin
            pc_en_n    = 1'b0;
            ifid_en_n  = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
          end
        end
        S_REDIR: begin
          imem_req   = 1'b1;
          pcj        = tgt_q;
          idex_flush = 1'b0;
          if (br_taken) begin
            tgt_d = br_target;
          end
          if (imem_ready) begin
            pc_src    = 1'b1;
            pc_en_n   = 1'b0;
            flush_inc = 1'b1;
            state_d   = S_RUN;
          end else begin
            stall_inc = 1'b1;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam int          CNT_W = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_ready, load_use_stall, br_taken;
  logic [31:0]      br_target;
  logic             imem_req, pc_src, pc_en_n, ifid_en_n, ifid_flush, idex_flush;
  logic [31:0]      pcj;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Model: booting one cycle after reset, a pending redirect with its target,
  // and the two saturating counts.
  bit          m_boot;
  bit          m_redir;
  logic [31:0] m_tgt;
  int          m_stall, m_flush;

  fetch_ctrl #(.RESET_VEC(RV), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ready     (imem_ready),
    .load_use_stall (load_use_stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_req       (imem_req),
    .pc_src         (pc_src),
    .pc_en_n        (pc_en_n),
    .pcj            (pcj),
    .ifid_en_n      (ifid_en_n),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_boot  = 1'b1;
    m_redir = 1'b0;
    m_tgt   = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic checkAll();
    bit e_req, e_src, e_en_n, e_ifid_en_n, e_iff, e_idf, chk_pcj;
    logic [31:0] e_pcj;
    e_req = 1'b0; e_src = 1'b0; e_en_n = 1'b1; e_ifid_en_n = 1'b1;
    e_iff = 1'b1; e_idf = 1'b1; chk_pcj = 1'b1; e_pcj = '0;
    if (!rst_n) begin
      // reset values already set
    end else if (m_boot) begin
      e_src = 1'b1; e_en_n = 1'b0; e_pcj = RV;
    end else if (m_redir) begin
      e_req = 1'b1; e_pcj = m_tgt; e_idf = 1'b0;
      e_src = imem_ready; e_en_n = !imem_ready;
    end else begin
      e_req = 1'b1;
      chk_pcj = 1'b0;
      if (br_taken) begin
        e_src = imem_ready; e_en_n = !imem_ready;
        if (imem_ready) begin
          chk_pcj = 1'b1; e_pcj = br_target;
        end
      end else if (load_use_stall) begin
        e_iff = 1'b0;
      end else if (!imem_ready) begin
        e_idf = 1'b0;
      end else begin
        e_en_n = 1'b0; e_ifid_en_n = 1'b0; e_iff = 1'b0; e_idf = 1'b0;
      end
    end
    checkOutput("imem_req", 32'(imem_req), 32'(e_req));
    checkOutput("pc_src", 32'(pc_src), 32'(e_src));
    checkOutput("pc_en_n", 32'(pc_en_n), 32'(e_en_n));
    checkOutput("ifid_en_n", 32'(ifid_en_n), 32'(e_ifid_en_n));
    checkOutput("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    checkOutput("idex_flush", 32'(idex_flush), 32'(e_idf));
    if (chk_pcj) checkOutput("pcj", pcj, e_pcj);
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    checkOutput("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  // Advance the model by one clock edge using the inputs that were checked.
  task automatic modelStep();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_redir) begin
      if (br_taken) m_tgt = br_target;
      if (imem_ready) begin
        m_redir = 1'b0;
        m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      end else begin
        m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      end
    end else if (br_taken) begin
      if (imem_ready) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      else begin
        m_redir = 1'b1;
        m_tgt   = br_target;
      end
    end else if (load_use_stall || !imem_ready) begin
      m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    end
  endtask

  task automatic applyStimulus(input bit rdy, input bit lu, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    imem_ready     = rdy;
    load_use_stall = lu;
    br_taken       = br;
    br_target      = tgt;
    #1 checkAll();
    @(posedge clk);
    modelStep();
  endtask

  // Async reset pulse released between edges; the boot cycle is checked too.
  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ready = 1'($urandom); load_use_stall = 1'($urandom);
    br_taken = 1'($urandom); br_target = $urandom;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    #1 checkAll();
    rst_n = 1'b1;
    #1 checkAll();
    @(posedge clk);
    modelStep();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; load_use_stall = 1'b0; br_taken = 1'b0; br_target = '0;
    modelReset();
    pulseReset();

    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 1, 1, 32'h200);
    applyStimulus(1, 1, 0, 32'h0);

    pulseReset();
    applyStimulus(0, 0, 1, 32'h300);
    applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);

    applyStimulus(0, 0, 1, 32'h440);
    applyStimulus(0, 0, 0, 32'h0);
    pulseReset();
    applyStimulus(1, 0, 0, 32'h0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulseReset();
      end else begin
        applyStimulus(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 25),
                      ($urandom_range(0, 99) < 15), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
